// File: rtl/updown_counter_pkg.sv
// Shared constants, operation encoding and load clamp helper for the up/down counter.
package updown_counter_pkg;

  localparam int CNT_WIDTH         = 4;
  localparam int DEFAULT_MAX_COUNT = 15;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_LOAD,
    OP_COUNT,
    OP_WRAP_UP,
    OP_WRAP_DOWN,
    OP_FORCE_ZERO
  } count_op_e;

  function automatic logic [CNT_WIDTH-1:0] clamp_load(
    input logic [CNT_WIDTH-1:0] d,
    input logic [CNT_WIDTH-1:0] max_q
  );
    return (d > max_q) ? max_q : d;
  endfunction

endpackage

// File: rtl/updown_bit_cell.sv
// One stored count bit: async clear, then synchronous load, then toggle.
module updown_bit_cell (
  input  logic Clk,
  input  logic nClr,
  input  logic load,
  input  logic load_bit,
  input  logic toggle,
  output logic q
);

  always_ff @(posedge Clk or negedge nClr) begin
    if (!nClr)
      q <= 1'b0;
    else if (load)
      q <= load_bit;
    else if (toggle)
      q <= ~q;
  end

endmodule

// File: rtl/updown_counter4.sv
// Four-bit up/down counter with clamped parallel load, modulo-(MAX_COUNT+1) wrap and sticky wrap flag.
module updown_counter4
  import updown_counter_pkg::*;
#(
  parameter int MAX_COUNT = DEFAULT_MAX_COUNT
) (
  input  logic                 Clk,
  input  logic                 nClr,
  input  logic                 nLoad,
  input  logic                 En,
  input  logic                 Up,
  input  logic [CNT_WIDTH-1:0] D,
  output logic [CNT_WIDTH-1:0] Q,
  output logic                 TC,
  output logic                 Ovf
);

  localparam logic [CNT_WIDTH-1:0] MAX_Q = CNT_WIDTH'(MAX_COUNT);

  count_op_e              op;
  logic                   at_top;
  logic                   at_bottom;
  logic                   over_range;
  logic                   load_en;
  logic [CNT_WIDTH-1:0]   load_val;
  logic [CNT_WIDTH-1:0]   toggle_en;
  logic                   carry;

  always_comb begin
    at_top     = (Q == MAX_Q);
    at_bottom  = (Q == '0);
    over_range = (Q > MAX_Q);
    op         = OP_HOLD;
    if (!nLoad)
      op = OP_LOAD;
    else if (En) begin
      if (over_range)
        op = OP_FORCE_ZERO;
      else if (Up && at_top)
        op = OP_WRAP_UP;
      else if (!Up && at_bottom)
        op = OP_WRAP_DOWN;
      else
        op = OP_COUNT;
    end
  end

  // Wraps and out-of-range recovery reuse the bit cells' load path; only plain counts toggle.
  always_comb begin
    load_en  = (op == OP_LOAD) || (op == OP_WRAP_UP) ||
               (op == OP_WRAP_DOWN) || (op == OP_FORCE_ZERO);
    load_val = '0;
    case (op)
      OP_LOAD:      load_val = clamp_load(D, MAX_Q);
      OP_WRAP_DOWN: load_val = MAX_Q;
      default:      load_val = '0;
    endcase
  end

  // A bit toggles when every lower bit is 1 (counting up) or 0 (counting down).
  always_comb begin
    carry     = 1'b1;
    toggle_en = '0;
    for (int i = 0; i < CNT_WIDTH; i++) begin
      toggle_en[i] = (op == OP_COUNT) && carry;
      carry        = carry && (Up ? Q[i] : ~Q[i]);
    end
  end

  for (genvar g = 0; g < CNT_WIDTH; g++) begin : g_bit
    updown_bit_cell u_cell (
      .Clk      (Clk),
      .nClr     (nClr),
      .load     (load_en),
      .load_bit (load_val[g]),
      .toggle   (toggle_en[g]),
      .q        (Q[g])
    );
  end

  assign TC = En && ((Up && at_top) || (!Up && at_bottom));

  always_ff @(posedge Clk or negedge nClr) begin
    if (!nClr)
      Ovf <= 1'b0;
    else if (op == OP_LOAD)
      Ovf <= 1'b0;
    else if ((op == OP_WRAP_UP) || (op == OP_WRAP_DOWN))
      Ovf <= 1'b1;
  end

endmodule
